// File: rtl/pixel_raster_walker_if.sv
// pixel_raster_walker_if: control and pixel-stream bundle between walker and its consumer
interface pixel_raster_walker_if #(
  parameter int IMAGEX = 256,
  parameter int IMAGEY = 256,
  parameter int IMAGEXlog2 = $clog2(IMAGEX),
  parameter int IMAGEYlog2 = $clog2(IMAGEY),
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGEX * IMAGEY)
);
  logic start;
  logic serpentine;
  logic abort;
  logic out_ready;
  logic out_valid;
  logic busy;
  logic [IMAGEXlog2-1:0] x;
  logic [IMAGEYlog2-1:0] y;
  logic dir;
  logic [IMAGE_ADDR_WIDTH-1:0] addr;
  logic [4*IMAGE_ADDR_WIDTH-1:0] nb_addr;
  logic [3:0] nb_valid;
  logic frame_done;
  modport master (
    output start, serpentine, abort, out_ready,
    input out_valid, busy, x, y, dir, addr, nb_addr, nb_valid, frame_done
  );
  modport slave (
    input start, serpentine, abort, out_ready,
    output out_valid, busy, x, y, dir, addr, nb_addr, nb_valid, frame_done
  );
endinterface

// File: rtl/pixel_raster_walker.sv
// pixel_raster_walker: raster/serpentine frame walker emitting Floyd-Steinberg neighbour addresses
module pixel_raster_walker #(
  parameter int IMAGEX = 256,
  parameter int IMAGEY = 256,
  parameter int IMAGEXlog2 = $clog2(IMAGEX),
  parameter int IMAGEYlog2 = $clog2(IMAGEY),
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGEX * IMAGEY)
) (
  input logic clk_i,
  input logic rst_ni,
  pixel_raster_walker_if.slave bus
);
  localparam int XW = IMAGEXlog2;
  localparam int YW = IMAGEYlog2;
  localparam int AW = IMAGE_ADDR_WIDTH;
  localparam logic [XW-1:0] XMAX = XW'(IMAGEX - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMAGEY - 1);
  localparam logic [AW-1:0] XSTEP = AW'(IMAGEX);
  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q;
  logic mode_q, out_valid_q, busy_q, done_q, dir_q, dir_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] base_q, base_d, addr_q, addr_d, below, xa, ax, bx;
  logic [3:0][AW-1:0] nb_q, nb_d;
  logic [3:0] nbv_q, nbv_d;
  logic load, adv, upd, row_end, last, ahead_ok, behind_ok, below_ok;
  always_comb begin
    load = state_q == IDLE && bus.start && !bus.abort;
    adv = state_q == RUN && out_valid_q && bus.out_ready && !bus.abort;
    row_end = dir_q ? x_q == '0 : x_q == XMAX;
    last = row_end && y_q == YMAX;
    upd = load || (adv && !last);
    // serpentine holds x across the row step; raster wraps to column 0
    x_d = load ? '0 : !row_end ? (dir_q ? x_q - 1'b1 : x_q + 1'b1) : mode_q ? x_q : '0;
    y_d = load ? '0 : row_end ? y_q + 1'b1 : y_q;
    dir_d = load ? 1'b0 : row_end ? mode_q & ~dir_q : dir_q;
    base_d = load ? '0 : row_end ? base_q + XSTEP : base_q;
    xa = AW'(x_d);
    below = base_d + XSTEP;
    ax = dir_d ? xa - 1'b1 : xa + 1'b1;
    bx = dir_d ? xa + 1'b1 : xa - 1'b1;
    ahead_ok = dir_d ? x_d != '0 : x_d != XMAX;
    behind_ok = dir_d ? x_d != XMAX : x_d != '0;
    below_ok = y_d != YMAX;
    addr_d = base_d + xa;
    nbv_d = {below_ok & ahead_ok, below_ok, below_ok & behind_ok, ahead_ok};
    nb_d[0] = nbv_d[0] ? base_d + ax : '0;
    nb_d[1] = nbv_d[1] ? below + bx : '0;
    nb_d[2] = nbv_d[2] ? below + xa : '0;
    nb_d[3] = nbv_d[3] ? below + ax : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      dir_q <= 1'b0;
      base_q <= '0;
      addr_q <= '0;
      nb_q <= '0;
      nbv_q <= '0;
    end else begin
      done_q <= adv && last;
      if (bus.abort) begin
        state_q <= IDLE;
        out_valid_q <= 1'b0;
        busy_q <= 1'b0;
      end else if (load) begin
        state_q <= RUN;
        out_valid_q <= 1'b1;
        busy_q <= 1'b1;
        mode_q <= bus.serpentine;
      end else if (adv && last) begin
        state_q <= IDLE;
        out_valid_q <= 1'b0;
        busy_q <= 1'b0;
      end
      if (upd) begin
        x_q <= x_d;
        y_q <= y_d;
        dir_q <= dir_d;
        base_q <= base_d;
        addr_q <= addr_d;
        nb_q <= nb_d;
        nbv_q <= nbv_d;
      end
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.busy = busy_q;
  assign bus.x = x_q;
  assign bus.y = y_q;
  assign bus.dir = dir_q;
  assign bus.addr = addr_q;
  assign bus.nb_addr = nb_q;
  assign bus.nb_valid = nbv_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_pixel_raster_walker.sv
// tb_pixel_raster_walker: scoreboard bench for a 4x3 frame in raster and serpentine order
module tb_pixel_raster_walker;
  localparam int IX = 4;
  localparam int IY = 3;
  typedef struct {
    int x;
    int y;
    bit dir;
    int addr;
    logic [15:0] nb;
    logic [3:0] nbv;
    bit last;
    bit b2b;
  } exp_t;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;
  pixel_raster_walker_if #(.IMAGEX(IX), .IMAGEY(IY)) bus();
  pixel_raster_walker #(.IMAGEX(IX), .IMAGEY(IY)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));
  exp_t sb[$];
  int errors = 0, checks = 0, accepted = 0, cyc = 0, done_cyc = -10, done_cnt = 0;
  int serp_tab[12] = '{0, 1, 2, 3, 7, 6, 5, 4, 8, 9, 10, 11};
  logic [28:0] cur, snap;
  logic [28:0] all_out;
  bit hold = 0, done_exp = 0, pop_last;
  exp_t e;
  assign cur = {bus.x, bus.y, bus.dir, bus.addr, bus.nb_addr, bus.nb_valid};
  assign all_out = {bus.out_valid, bus.busy, bus.x, bus.y, bus.dir, bus.addr, bus.nb_addr, bus.nb_valid, bus.frame_done};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int a, input bit serp, input bit last, input bit b2b);
    exp_t r;
    int ah, bh;
    bit bl;
    r.x = a % IX;
    r.y = a / IX;
    r.addr = a;
    r.dir = serp && (r.y % 2 == 1);
    ah = r.dir ? r.x - 1 : r.x + 1;
    bh = r.dir ? r.x + 1 : r.x - 1;
    bl = r.y + 1 < IY;
    r.nbv[0] = ah >= 0 && ah < IX;
    r.nbv[1] = bl && bh >= 0 && bh < IX;
    r.nbv[2] = bl;
    r.nbv[3] = bl && r.nbv[0];
    r.nb = '0;
    if (r.nbv[0]) r.nb[3:0] = 4'(r.y * IX + ah);
    if (r.nbv[1]) r.nb[7:4] = 4'((r.y + 1) * IX + bh);
    if (r.nbv[2]) r.nb[11:8] = 4'((r.y + 1) * IX + r.x);
    if (r.nbv[3]) r.nb[15:12] = 4'((r.y + 1) * IX + ah);
    r.last = last;
    r.b2b = b2b;
    return r;
  endfunction

  task automatic push_frame(input bit serp, input bit b2b);
    for (int i = 0; i < 12; i++) sb.push_back(mk(serp ? serp_tab[i] : i, serp, i == 11, b2b && i == 0));
  endtask

  task automatic start_frame(input bit serp);
    bus.serpentine = serp;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL timeout: %0d pixels still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (bus.frame_done || done_exp) chk("frame_done", bus.frame_done, done_exp);
    if (bus.frame_done) begin
      done_cyc = cyc;
      done_cnt++;
    end
    pop_last = 0;
    if (hold && bus.out_valid) chk("hold_stable", cur, snap);
    if (bus.out_valid && bus.out_ready) begin
      accepted++;
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_pixel: got addr %0d, required none", bus.addr);
      end else begin
        e = sb.pop_front();
        chk("pixel", cur, {2'(e.x), 2'(e.y), e.dir, 4'(e.addr), e.nb, e.nbv});
        if (e.x == 1 && e.y == 1 && !e.dir) begin
          chk("nb_1_1", bus.nb_addr, 16'hA986);
          chk("nbv_1_1", bus.nb_valid, 4'hF);
        end
        if (e.x == 3 && e.y == 2) chk("nbv_3_2", bus.nb_valid, 4'h0);
        if (e.x == 2 && e.y == 1 && e.dir) begin
          chk("nb_2_1_serp", bus.nb_addr, 16'h9AB5);
          chk("nbv_2_1_serp", bus.nb_valid, 4'hF);
        end
        if (e.b2b) chk("b2b_gap", cyc - done_cyc, 1);
        pop_last = e.last;
      end
    end
    done_exp = pop_last;
    hold = rst_ni && bus.out_valid && !bus.out_ready;
    snap = cur;
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.serpentine = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", all_out, 0);
    rst_ni = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_no_start", bus.out_valid, 0);
    // asynchronous reset in the middle of a frame
    for (int a = 0; a < 3; a++) sb.push_back(mk(a, 0, 0, 0));
    bus.out_ready = 1'b1;
    start_frame(0);
    wait_empty(50);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1 chk("async_reset", all_out, 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("no_done_on_reset", done_cnt, 0);
    // raster walk at full rate
    push_frame(0, 0);
    bus.out_ready = 1'b1;
    start_frame(0);
    wait_empty(100);
    repeat (2) @(posedge clk);
    #1 chk("raster_done_count", done_cnt, 1);
    chk("idle_after_frame", {bus.busy, bus.out_valid}, 0);
    chk("hold_last_addr", bus.addr, 11);
    // serpentine walk under random backpressure
    push_frame(1, 0);
    accepted = 0;
    start_frame(1);
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1 bus.out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL serp_timeout: %0d pixels pending, required 0", sb.size());
      sb.delete();
    end
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("serp_accepted", accepted, 12);
    chk("serp_done_count", done_cnt, 2);
    // abort while pixel 5 is presented
    for (int a = 0; a < 5; a++) sb.push_back(mk(a, 0, 0, 0));
    start_frame(0);
    wait_empty(50);
    #1 bus.out_ready = 1'b0;
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    chk("abort_idle", {bus.out_valid, bus.busy}, 0);
    repeat (3) @(posedge clk);
    #1 chk("abort_no_done", done_cnt, 2);
    push_frame(1, 0);
    bus.out_ready = 1'b1;
    start_frame(1);
    wait_empty(100);
    repeat (2) @(posedge clk);
    #1 chk("restart_done_count", done_cnt, 3);
    // start held through frame_done: second frame follows immediately
    push_frame(0, 0);
    push_frame(0, 1);
    bus.serpentine = 1'b0;
    bus.start = 1'b1;
    n = 0;
    while (sb.size() > 10 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1 bus.start = 1'b0;
    wait_empty(100);
    repeat (2) @(posedge clk);
    #1 chk("b2b_done_count", done_cnt, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pixel_raster_walker.md
Name: pixel_raster_walker

Overview:
- Parametrised successor to the linear pixel counter: walks an IMAGEX x IMAGEY frame in raster or serpentine order.
- Emits (x, y), the linear address and the four Floyd-Steinberg error-diffusion neighbour addresses with validity flags.
- Sits between the SPI frame loader and the dither datapath; the datapath pulls one pixel per out_valid/out_ready handshake.

Parameters:
IMAGEX, 256, frame width in pixels (>=2, any value, not only powers of two)
IMAGEY, 256, frame height in pixels (>=2)
IMAGEXlog2, $clog2(IMAGEX), x coordinate width
IMAGEYlog2, $clog2(IMAGEY), y coordinate width
IMAGE_ADDR_WIDTH, $clog2(IMAGEX*IMAGEY), linear address width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin a frame; sampled only in IDLE
serpentine  input  1  0 = raster, 1 = serpentine; latched when start is accepted
abort  input  1  synchronous abort to IDLE, from any state
out_ready  input  1  consumer accepts the current pixel
out_valid  output  1  current pixel outputs are valid
busy  output  1  high in RUN
x  output  IMAGEXlog2  current column
y  output  IMAGEYlog2  current row
dir  output  1  0 = left-to-right, 1 = right-to-left for the current row
addr  output  IMAGE_ADDR_WIDTH  y*IMAGEX + x
nb_addr  output  4*IMAGE_ADDR_WIDTH  neighbour addresses, slices [0]=ahead, [1]=below-behind, [2]=below, [3]=below-ahead
nb_valid  output  4  per-neighbour in-frame flag
frame_done  output  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0: out_valid, busy, x, y, dir, addr, nb_addr, nb_valid, frame_done. Latched mode = 0.
- States: IDLE, RUN.
- IDLE with start=1 and abort=0: next edge enters RUN, latches serpentine, sets x=0, y=0, dir=0, out_valid=1, busy=1. All pixel outputs are registered and coherent in that same cycle.
- RUN: advance occurs only on out_valid & out_ready. Outputs hold stable while out_ready=0.
- Advance, raster mode: x increments; at x=IMAGEX-1, x wraps to 0 and y increments. dir stays 0.
- Advance, serpentine mode: moves in the dir direction. At the row end (x=IMAGEX-1 with dir=0, or x=0 with dir=1), y increments, x holds its value, and dir toggles. Even rows run left-to-right, odd rows right-to-left.
- "Ahead" = x+1 when dir=0, x-1 when dir=1. "Behind" is the opposite.
- Neighbours:
  - ahead = (ahead_x, y)
  - below-behind = (behind_x, y+1)
  - below = (x, y+1)
  - below-ahead = (ahead_x, y+1)
- nb_valid bit is 1 only when the neighbour coordinate lies inside the frame. Invalid slices drive address 0.
- Addresses are computed without a multiplier: keep a registered row base (y*IMAGEX) and add IMAGEX at each row step. Arithmetic is unsigned at IMAGE_ADDR_WIDTH; no wrap is ever produced for valid slices.
- Last pixel:
  - raster: (IMAGEX-1, IMAGEY-1)
  - serpentine: x=IMAGEX-1 when IMAGEY is odd, x=0 when IMAGEY is even, with y=IMAGEY-1
- When the last pixel is accepted: next edge returns to IDLE, out_valid=0, busy=0, frame_done=1 for exactly one cycle. x, y and addr hold their last values.
- start while in RUN is ignored. start in the same cycle as the frame_done pulse (state is already IDLE) is accepted normally.
- abort=1: next edge goes to IDLE with out_valid=0 and busy=0. No frame_done pulse. abort has priority over start and over an advance.
- Reset mid-frame: immediate return to the reset values; no frame_done pulse.

Test Plan:
- Reset and idle: IMAGEX=4, IMAGEY=3, rst low mid-RUN → all outputs 0 asynchronously. Release rst with no start → out_valid stays 0.
- Raster walk: start, serpentine=0, out_ready=1 → 12 pixels, addr 0..11 in order. At (1,1): nb_addr={6,8,9,10}, nb_valid=4'b1111. At (3,2): nb_valid=0 (no ahead neighbour, no row below). frame_done pulses once, one cycle after addr 11 is accepted.
- Serpentine walk: IMAGEX=4, IMAGEY=3 → addr sequence 0,1,2,3,7,6,5,4,8,9,10,11 with dir 0,1,0 per row. At (2,1), dir=1: ahead=5, below-behind=11, below=10, below-ahead=9, all valid.
- Backpressure: toggle out_ready pseudo-randomly → no pixel skipped or repeated. Outputs stable while out_ready=0. Total accepted count = 12.
- Abort: assert abort at pixel 5 → IDLE next cycle, no frame_done. A new start restarts at addr 0 with the newly latched mode.
- Back-to-back: start held high through frame_done → second frame begins in the cycle after the pulse, at addr 0.
